// File: rtl/votes_tally.sv
// Sequential N-voter ballot tally: collects one ballot per voter, closes on all-voted or timeout.
// Optional quorum gating of the decision is enabled with `define VOTES_QUORUM_EN.
module votes_tally #(
    parameter int N_VOTERS  = 4,
    parameter int THRESHOLD = 3,
    parameter int TIMEOUT   = 16
`ifdef VOTES_QUORUM_EN
    ,
    parameter int QUORUM    = 3
`endif
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [N_VOTERS-1:0]                vote_valid,
    input  logic [N_VOTERS-1:0]                vote_val,
    output logic                               busy,
    output logic [N_VOTERS-1:0]                voted,
    output logic [$clog2(N_VOTERS+1)-1:0]      yes_count,
    output logic [$clog2(N_VOTERS+1)-1:0]      no_count,
    output logic                               result,
    output logic                               result_valid,
    output logic                               timed_out,
`ifdef VOTES_QUORUM_EN
    output logic                               quorum_met,
`endif
    output logic                               dup_err
);

    localparam int CNT_W = $clog2(N_VOTERS + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] THR_C   = CNT_W'(THRESHOLD);
    localparam logic [TMR_W-1:0] TO_C    = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1'b1);

    if (N_VOTERS < 2) begin : g_bad_n
        $error("votes_tally: N_VOTERS must be at least 2");
    end
    if (THRESHOLD < 1 || THRESHOLD > N_VOTERS) begin : g_bad_thr
        $error("votes_tally: THRESHOLD must be in 1..N_VOTERS");
    end
    if (TIMEOUT < 1) begin : g_bad_to
        $error("votes_tally: TIMEOUT must be at least 1");
    end
`ifdef VOTES_QUORUM_EN
    if (QUORUM < 1 || QUORUM > N_VOTERS) begin : g_bad_quo
        $error("votes_tally: QUORUM must be in 1..N_VOTERS");
    end
    localparam logic [CNT_W:0] QUO_C = (CNT_W + 1)'(QUORUM);
    logic quorum_met_q, quorum_met_d;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic [CNT_W-1:0]    yes_q, yes_d;
    logic [CNT_W-1:0]    no_q, no_d;
    logic                result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                timed_out_q, timed_out_d;
    logic                dup_err_q, dup_err_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [N_VOTERS-1:0] accept_s;
    logic [CNT_W-1:0]    yes_add_s, no_add_s;
    logic                thr_ok_s;

    // Next-state and next-output computation for the round FSM
    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        voted_d        = voted_q;
        yes_d          = yes_q;
        no_d           = no_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        timed_out_d    = timed_out_q;
        dup_err_d      = 1'b0;
        timer_d        = timer_q;
        accept_s       = {N_VOTERS{1'b0}};
        yes_add_s      = {CNT_W{1'b0}};
        no_add_s       = {CNT_W{1'b0}};
        thr_ok_s       = 1'b0;
`ifdef VOTES_QUORUM_EN
        quorum_met_d   = quorum_met_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_COLLECT;
                    busy_d      = 1'b1;
                    voted_d     = {N_VOTERS{1'b0}};
                    yes_d       = {CNT_W{1'b0}};
                    no_d        = {CNT_W{1'b0}};
                    result_d    = 1'b0;
                    timed_out_d = 1'b0;
                    timer_d     = {TMR_W{1'b0}};
`ifdef VOTES_QUORUM_EN
                    quorum_met_d = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                // Only first ballots count; repeats are flagged and dropped
                accept_s  = vote_valid & ~voted_q;
                dup_err_d = |(vote_valid & voted_q);
                for (int i = 0; i < N_VOTERS; i++) begin
                    yes_add_s = yes_add_s + {{(CNT_W-1){1'b0}}, (accept_s[i] & vote_val[i])};
                    no_add_s  = no_add_s  + {{(CNT_W-1){1'b0}}, (accept_s[i] & ~vote_val[i])};
                end
                voted_d  = voted_q | accept_s;
                yes_d    = yes_q + yes_add_s;
                no_d     = no_q + no_add_s;
                timer_d  = timer_q + TMR_ONE;
                thr_ok_s = (yes_d >= THR_C);
                if ((&voted_d) || (timer_d == TO_C)) begin
                    state_d        = S_DONE;
                    result_valid_d = 1'b1;
                    timed_out_d    = ~(&voted_d);
`ifdef VOTES_QUORUM_EN
                    quorum_met_d   = (({1'b0, yes_d} + {1'b0, no_d}) >= QUO_C);
                    result_d       = quorum_met_d & thr_ok_s;
`else
                    result_d       = thr_ok_s;
`endif
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            voted_q        <= {N_VOTERS{1'b0}};
            yes_q          <= {CNT_W{1'b0}};
            no_q           <= {CNT_W{1'b0}};
            result_q       <= 1'b0;
            result_valid_q <= 1'b0;
            timed_out_q    <= 1'b0;
            dup_err_q      <= 1'b0;
            timer_q        <= {TMR_W{1'b0}};
`ifdef VOTES_QUORUM_EN
            quorum_met_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            voted_q        <= voted_d;
            yes_q          <= yes_d;
            no_q           <= no_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timed_out_q    <= timed_out_d;
            dup_err_q      <= dup_err_d;
            timer_q        <= timer_d;
`ifdef VOTES_QUORUM_EN
            quorum_met_q   <= quorum_met_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign voted        = voted_q;
    assign yes_count    = yes_q;
    assign no_count     = no_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign timed_out    = timed_out_q;
    assign dup_err      = dup_err_q;
`ifdef VOTES_QUORUM_EN
    assign quorum_met   = quorum_met_q;
`endif

endmodule

// File: tb/tb_votes_tally.sv
// Self-checking bench for votes_tally: two instances (THRESHOLD 3 and 2) share one stimulus stream
// and are compared every cycle against a ballot-level model plus directed literal checks.
module tb_votes_tally;
    localparam int N  = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] vote_valid, vote_val;

    logic       busy_a, result_a, rv_a, to_a, dup_a;
    logic [3:0] voted_a;
    logic [2:0] yes_a, no_a;
    logic       busy_b, result_b, rv_b, to_b, dup_b;
    logic [3:0] voted_b;
    logic [2:0] yes_b, no_b;
`ifdef VOTES_QUORUM_EN
    logic       qm_a, qm_b;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    votes_tally #(.N_VOTERS(N), .THRESHOLD(3), .TIMEOUT(TO)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .vote_valid(vote_valid), .vote_val(vote_val),
        .busy(busy_a), .voted(voted_a), .yes_count(yes_a), .no_count(no_a), .result(result_a),
        .result_valid(rv_a), .timed_out(to_a),
`ifdef VOTES_QUORUM_EN
        .quorum_met(qm_a),
`endif
        .dup_err(dup_a));

    votes_tally #(.N_VOTERS(N), .THRESHOLD(2), .TIMEOUT(TO)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .vote_valid(vote_valid), .vote_val(vote_val),
        .busy(busy_b), .voted(voted_b), .yes_count(yes_b), .no_count(no_b), .result(result_b),
        .result_valid(rv_b), .timed_out(to_b),
`ifdef VOTES_QUORUM_EN
        .quorum_met(qm_b),
`endif
        .dup_err(dup_b));

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 collecting, 2 done; ballot[i] = -1 (none), 0 (no), 1 (yes)
    int   m_phase = 0;
    int   ballot[N];
    int   m_cycles = 0;
    logic m_rv = 1'b0, m_dup = 1'b0, m_to = 1'b0, m_res_a = 1'b0, m_res_b = 1'b0, m_qm = 1'b0;

    function automatic int nyes();
        int c = 0;
        for (int i = 0; i < N; i++) if (ballot[i] == 1) c++;
        return c;
    endfunction
    function automatic int nno();
        int c = 0;
        for (int i = 0; i < N; i++) if (ballot[i] == 0) c++;
        return c;
    endfunction
    function automatic logic [3:0] mmask();
        logic [3:0] m = 4'b0000;
        for (int i = 0; i < N; i++) m[i] = (ballot[i] != -1);
        return m;
    endfunction

    initial for (int i = 0; i < N; i++) ballot[i] = -1;

    always @(posedge clk) begin
        m_rv  = 1'b0;
        m_dup = 1'b0;
        if (rst) begin
            m_phase = 0;
            for (int i = 0; i < N; i++) ballot[i] = -1;
            m_to = 1'b0; m_res_a = 1'b0; m_res_b = 1'b0; m_qm = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase = 1; m_cycles = 0;
                for (int i = 0; i < N; i++) ballot[i] = -1;
                m_to = 1'b0; m_res_a = 1'b0; m_res_b = 1'b0; m_qm = 1'b0;
            end
        end else if (m_phase == 1) begin
            for (int i = 0; i < N; i++) begin
                if (vote_valid[i] && ballot[i] != -1) m_dup = 1'b1;
                else if (vote_valid[i]) ballot[i] = vote_val[i] ? 1 : 0;
            end
            m_cycles++;
            if (mmask() == 4'b1111 || m_cycles == TO) begin
                m_phase = 2;
                m_rv    = 1'b1;
                m_to    = (mmask() != 4'b1111);
`ifdef VOTES_QUORUM_EN
                m_qm    = (nyes() + nno()) >= 3;
`else
                m_qm    = 1'b1;
`endif
                m_res_a = m_qm && (nyes() >= 3);
                m_res_b = m_qm && (nyes() >= 2);
            end
        end else begin
            m_phase = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_a",   busy_a,  m_phase != 0);
            chk("busy_b",   busy_b,  m_phase != 0);
            chk("voted_a",  voted_a, mmask());
            chk("voted_b",  voted_b, mmask());
            chk("yes_a",    yes_a,   nyes());
            chk("no_a",     no_a,    nno());
            chk("yes_b",    yes_b,   nyes());
            chk("no_b",     no_b,    nno());
            chk("rv_a",     rv_a,    m_rv);
            chk("rv_b",     rv_b,    m_rv);
            chk("to_a",     to_a,    m_to);
            chk("to_b",     to_b,    m_to);
            chk("dup_a",    dup_a,   m_dup);
            chk("dup_b",    dup_b,   m_dup);
            chk("result_a", result_a, m_res_a);
            chk("result_b", result_b, m_res_b);
`ifdef VOTES_QUORUM_EN
            chk("qm_a",     qm_a,    m_phase == 0 && !rst ? m_qm && 1'b1 : m_qm);
`endif
        end
    end

    task automatic tick(input logic s, input logic [3:0] vv, input logic [3:0] vl);
        @(negedge clk);
        start = s; vote_valid = vv; vote_val = vl;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vote_valid = 4'b0000; vote_val = 4'b0000;
        @(posedge clk);
        chk_en = 1'b1;
        tick(1'b0, 4'b0000, 4'b0000);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_yes", yes_a, 3'd0);
        chk("rst_rv", rv_a, 1'b0);
        @(negedge clk); rst = 1'b0;

        // Single-cycle full round; ballots in the start cycle are ignored
        tick(1'b1, 4'b1111, 4'b1111);
        chk("t1_busy_collect", busy_a, 1'b1);
        chk("t1_no_early_vote", voted_a, 4'b0000);
        tick(1'b0, 4'b1111, 4'b0111);
        chk("t1_rv", rv_a, 1'b1);
        chk("t1_yes", yes_a, 3'd3);
        chk("t1_no", no_a, 3'd1);
        chk("t1_result", result_a, 1'b1);
        chk("t1_to", to_a, 1'b0);
        tick(1'b0, 4'b0000, 4'b0000);
        chk("t1_busy_off", busy_a, 1'b0);
        chk("t1_rv_pulse", rv_a, 1'b0);
        chk("t1_hold_yes", yes_a, 3'd3);

        // Split round, 2 yes / 2 no; start mid-round is ignored
        tick(1'b1, 4'b0000, 4'b0000);
        tick(1'b0, 4'b0011, 4'b0011);
        tick(1'b1, 4'b0000, 4'b0000);
        tick(1'b0, 4'b1100, 4'b0000);
        chk("t2_rv", rv_a, 1'b1);
        chk("t2_yes", yes_a, 3'd2);
        chk("t2_no", no_a, 3'd2);
        chk("t2_result_a", result_a, 1'b0);
        tick(1'b0, 4'b1111, 4'b1111);
        chk("t2_idle_nodup", dup_a, 1'b0);

        // Timeout round with two yes voters
        tick(1'b1, 4'b0000, 4'b0000);
        tick(1'b0, 4'b0011, 4'b0011);
        for (int k = 1; k <= 15; k++) begin
            tick(1'b0, 4'b0000, 4'b0000);
            if (k == 14) chk("t3_not_yet", rv_a, 1'b0);
        end
        chk("t3_rv", rv_a, 1'b1);
        chk("t3_to", to_a, 1'b1);
        chk("t3_yes", yes_a, 3'd2);
        chk("t3_voted", voted_a, 4'b0011);
        chk("t3_result_a", result_a, 1'b0);
`ifdef VOTES_QUORUM_EN
        chk("t3_qm_b", qm_b, 1'b0);
        chk("t3_result_b", result_b, 1'b0);
`else
        chk("t3_result_b", result_b, 1'b1);
`endif
        tick(1'b0, 4'b0000, 4'b0000);

        // Duplicate ballot from voter 0
        tick(1'b1, 4'b0000, 4'b0000);
        tick(1'b0, 4'b0001, 4'b0001);
        tick(1'b0, 4'b0001, 4'b0000);
        chk("t4_dup", dup_a, 1'b1);
        chk("t4_yes", yes_a, 3'd1);
        chk("t4_no", no_a, 3'd0);
        tick(1'b0, 4'b0000, 4'b0000);
        chk("t4_dup_pulse", dup_a, 1'b0);
        tick(1'b0, 4'b1111, 4'b0000);
        chk("t4_dup_mixed", dup_a, 1'b1);
        chk("t4_no_final", no_a, 3'd3);
        chk("t4_rv", rv_a, 1'b1);
        tick(1'b0, 4'b0000, 4'b0000);

        // Reset mid-round, then a clean unanimous round
        tick(1'b1, 4'b0000, 4'b0000);
        tick(1'b0, 4'b0011, 4'b0001);
        @(negedge clk); rst = 1'b1; vote_valid = 4'b0000;
        @(posedge clk); #2;
        chk("t5_busy", busy_a, 1'b0);
        chk("t5_yes", yes_a, 3'd0);
        chk("t5_voted", voted_a, 4'b0000);
        @(negedge clk); rst = 1'b0;
        tick(1'b0, 4'b0000, 4'b0000);
        chk("t5_no_rv", rv_a, 1'b0);
        tick(1'b1, 4'b0000, 4'b0000);
        tick(1'b0, 4'b1111, 4'b1111);
        chk("t5_yes4", yes_a, 3'd4);
        chk("t5_result", result_a, 1'b1);
        tick(1'b0, 4'b0000, 4'b0000);

        // Final ballot on the timeout cycle: all-voted wins
        tick(1'b1, 4'b0000, 4'b0000);
        tick(1'b0, 4'b0111, 4'b0111);
        for (int k = 1; k <= 14; k++) tick(1'b0, 4'b0000, 4'b0000);
        tick(1'b0, 4'b1000, 4'b0000);
        chk("t6_rv", rv_a, 1'b1);
        chk("t6_to", to_a, 1'b0);
        chk("t6_yes", yes_a, 3'd3);
        chk("t6_no", no_a, 3'd1);
        tick(1'b0, 4'b0000, 4'b0000);
        tick(1'b0, 4'b0000, 4'b0000);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/votes_tally.md
Name: votes_tally

Overview:
- Parametrised, sequential successor to the fixed 4-input combinational majority voter.
- Runs a voting round over N_VOTERS independent voter channels. Each voter casts at most one yes/no ballot through a valid strobe.
- Closes the round when all voters have voted or a timeout expires, then reports registered yes/no counts and a threshold decision.
- Sits between voter front-ends and the decision/consumer logic.

Parameters:
- N_VOTERS, 4, number of voter channels (≥2).
- THRESHOLD, 3, minimum yes votes for result=1 (1..N_VOTERS; violation is an elaboration-time error).
- TIMEOUT, 16, maximum COLLECT cycles per round (≥1).
- CNT_W (localparam), $clog2(N_VOTERS+1), width of the count outputs.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  opens a round; honoured only in IDLE.
- vote_valid  in  N_VOTERS  per-voter ballot strobe.
- vote_val  in  N_VOTERS  per-voter ballot value, 1=yes, 0=no; sampled with vote_valid.
- busy  out  1  high in COLLECT and DONE.
- voted  out  N_VOTERS  mask of voters accepted this round.
- yes_count  out  CNT_W  accepted yes ballots.
- no_count  out  CNT_W  accepted no ballots.
- result  out  1  decision, (yes_count >= THRESHOLD).
- result_valid  out  1  one-cycle pulse when the round closes.
- timed_out  out  1  round closed by timeout.
- dup_err  out  1  one-cycle pulse on a repeated ballot.

Behaviour:
- Clock and reset: single clock, clk. Reset rst is synchronous and active-high. While rst=1 at an edge, the state goes to IDLE and every output is cleared to 0.
- States:
  - IDLE: start=1 → COLLECT. On that edge, clear voted, yes_count, no_count, result, timed_out and the timer. Ballots presented in the start cycle are ignored.
  - COLLECT: for every i with vote_valid[i]=1 and voted[i]=0, set voted[i] and add vote_val[i] to yes_count or no_count. Several voters may be accepted in the same cycle; the counts increase by the popcount of accepted yes/no ballots. The timer increments once per COLLECT cycle.
  - Close condition: after the cycle's acceptances, either all bits of voted are set, or the timer has reached TIMEOUT COLLECT cycles. On close → DONE.
  - Simultaneous close: if the final ballot arrives on the timeout cycle, it is counted and timed_out=0 (all-voted takes priority).
  - DONE: lasts exactly one cycle. result_valid=1, result=(yes_count>=THRESHOLD), and timed_out=1 only if the round closed on the timer. Then → IDLE.
- Latency: result_valid asserts in the cycle after the edge that accepted the last ballot, or after the TIMEOUT-th COLLECT cycle. Minimum is 2 cycles after start is sampled.
- Held outputs: counts, voted, result and timed_out hold their values in IDLE until the next accepted start.
- start handling: start in COLLECT or DONE is ignored; it is not queued.
- dup_err: vote_valid[i]=1 in COLLECT with voted[i] already 1 produces a one-cycle dup_err pulse, registered to the next cycle. The ballot is discarded and accepted ballots from other voters that cycle are unaffected. vote_valid outside COLLECT is ignored and does not raise dup_err.
- Counts never exceed N_VOTERS, so no saturation logic is needed.
- Reset mid-round abandons the round: no result_valid is produced, and all counts and the voted mask are cleared.

Optional Feature:
- Macro: VOTES_QUORUM_EN.
- Defined:
  - Adds parameter QUORUM (default 3, 1..N_VOTERS) and output port quorum_met (1 bit, reset 0).
  - In DONE, quorum_met=((yes_count+no_count) >= QUORUM).
  - result = quorum_met & (yes_count >= THRESHOLD). A round without quorum always reports result=0.
- Undefined: no QUORUM parameter and no quorum_met port; result depends on THRESHOLD only.

Test Plan:
- Defaults; start, then next cycle vote_valid=4'b1111, vote_val=4'b0111 → following cycle result_valid=1, yes_count=3, no_count=1, result=1, timed_out=0; busy=0 one cycle later.
- Defaults; voters 0,1 vote yes in cycle 1 and voters 2,3 vote no in cycle 3 → result_valid the cycle after cycle 3, yes=2, no=2, result=0.
- TIMEOUT=16; only voters 0 and 1 vote yes → result_valid after 16 COLLECT cycles, timed_out=1, yes_count=2, voted=4'b0011, result=0.
- Voter 0 votes yes, then asserts vote_valid again with vote_val=0 → dup_err pulses once, yes_count stays 1, no_count stays 0.
- rst=1 mid-COLLECT with 2 ballots counted → next cycle all outputs 0, busy=0, no result_valid; a new start and four yes votes give yes_count=4, result=1.
- VOTES_QUORUM_EN, QUORUM=3, THRESHOLD=2; 2 yes votes, then timeout → quorum_met=0, result=0. Same stimulus with the macro undefined → result=1.
